// File: rtl/interrupt_controller.sv
// interrupt_controller
// Prioritised, edge-triggered interrupt controller for the multicycle CPU.
// Collects rising edges on NUM_IRQ maskable lines and one NMI line, offers
// the highest-priority unmasked request (index 0 = highest) on int_out/vector,
// and tracks in-service state until the CPU pulses eoi.
// Build option: define NESTING_EN to allow a higher-priority request to
// pre-empt an interrupt that is already in service (nested servicing).
module interrupt_controller #(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               nmi_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               int_ack,
    input  logic               eoi,
    output logic               int_out,
    output logic               nmi_out,
    output logic [VEC_W-1:0]   vector,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] in_service
);

    // REQ_NEST is only reachable when nesting is compiled in.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        SERVICE  = 2'd2,
        REQ_NEST = 2'd3
    } state_t;

    // Registered state
    state_t             state_reg;
    logic [NUM_IRQ-1:0] mask_reg;
    logic [NUM_IRQ-1:0] pending_reg;
    logic [NUM_IRQ-1:0] in_service_reg;
    logic [NUM_IRQ-1:0] irq_q;
    logic               nmi_pend_reg;
    logic               nmi_q;
    logic               ack_q;
    logic               int_out_reg;
    logic [VEC_W-1:0]   vector_reg;

    // Combinational helpers
    logic [NUM_IRQ-1:0] irq_rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] vector_onehot;
    logic [NUM_IRQ-1:0] pending_clr;
    logic [NUM_IRQ-1:0] pending_next;
    logic [NUM_IRQ-1:0] service_set;
    logic [NUM_IRQ-1:0] service_clr;
    logic [NUM_IRQ-1:0] service_next;
    logic               nmi_rise;
    logic               ack_rise;
    logic               cpu_ack;
    logic               nmi_ack;
    logic               take_ack;
    logic               eoi_taken;
    logic               winner_valid;
    logic [VEC_W-1:0]   winner;
`ifdef NESTING_EN
    logic [VEC_W-1:0]   service_lowest;
    logic [VEC_W-1:0]   service_next_lowest;
    logic               nest_preempt;
`endif

    // Index of the lowest set bit (highest priority); 0 when no bit is set.
    function automatic logic [VEC_W-1:0] lowest_index(input logic [NUM_IRQ-1:0] bits);
        logic [VEC_W-1:0] idx;
        idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (bits[i]) begin
                idx = VEC_W'(i);
            end
        end
        return idx;
    endfunction

    // Previous-cycle copies of the request, NMI and acknowledge lines for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= '0;
            nmi_q <= 1'b0;
            ack_q <= 1'b0;
        end else begin
            irq_q <= irq;
            nmi_q <= nmi_in;
            ack_q <= int_ack;
        end
    end

    // Mask register: comes out of reset with every line masked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_reg <= '1;
        end else if (mask_we) begin
            mask_reg <= mask_wdata;
        end
    end

    // Event decode, arbitration and the set/clear vectors for pending and in-service.
    always_comb begin
        irq_rise      = irq & ~irq_q;
        nmi_rise      = nmi_in & ~nmi_q;
        ack_rise      = int_ack & ~ack_q;
        // A pending NMI always absorbs the acknowledge first.
        nmi_ack       = ack_rise & nmi_pend_reg;
        cpu_ack       = ack_rise & ~nmi_pend_reg;

        eligible      = pending_reg & ~mask_reg;
        winner_valid  = |eligible;
        winner        = lowest_index(eligible);

        vector_onehot = NUM_IRQ'(1) << vector_reg;
        take_ack      = cpu_ack && ((state_reg == REQ) || (state_reg == REQ_NEST));
        eoi_taken     = eoi && (state_reg == SERVICE);

        pending_clr   = take_ack ? vector_onehot : '0;
        service_set   = take_ack ? vector_onehot : '0;
`ifdef NESTING_EN
        // With nesting, the most recently entered (lowest index) handler finishes first.
        service_lowest = lowest_index(in_service_reg);
        service_clr    = eoi_taken ? (NUM_IRQ'(1) << service_lowest) : '0;
`else
        service_clr    = eoi_taken ? vector_onehot : '0;
`endif
        // A fresh edge in the same cycle as the acknowledge keeps the bit set.
        pending_next   = (pending_reg & ~pending_clr) | irq_rise;
        service_next   = (in_service_reg & ~service_clr) | service_set;
`ifdef NESTING_EN
        service_next_lowest = lowest_index(service_next);
        nest_preempt        = winner_valid && (winner < service_lowest);
`endif
    end

    // Per-line pending and in-service flops.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_line
            // Pending bit for line gi.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pending_reg[gi] <= 1'b0;
                end else begin
                    pending_reg[gi] <= pending_next[gi];
                end
            end

            // In-service bit for line gi.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    in_service_reg[gi] <= 1'b0;
                end else begin
                    in_service_reg[gi] <= service_next[gi];
                end
            end
        end
    endgenerate

    // NMI pending flag: set on an nmi_in edge, consumed by an acknowledge; a new edge wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_pend_reg <= 1'b0;
        end else if (nmi_rise) begin
            nmi_pend_reg <= 1'b1;
        end else if (nmi_ack) begin
            nmi_pend_reg <= 1'b0;
        end
    end

    // Offer/acknowledge/service sequencer with registered int_out and vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            int_out_reg <= 1'b0;
            vector_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (winner_valid) begin
                        state_reg   <= REQ;
                        vector_reg  <= winner;
                        int_out_reg <= 1'b1;
                    end
                end
                REQ: begin
                    // vector stays frozen here whatever arbitration does meanwhile.
                    if (cpu_ack) begin
                        state_reg   <= SERVICE;
                        int_out_reg <= 1'b0;
                    end
                end
                SERVICE: begin
`ifdef NESTING_EN
                    if (eoi) begin
                        if (service_next == '0) begin
                            state_reg <= IDLE;
                        end else begin
                            vector_reg <= service_next_lowest;
                        end
                    end else if (nest_preempt) begin
                        state_reg   <= REQ_NEST;
                        vector_reg  <= winner;
                        int_out_reg <= 1'b1;
                    end
`else
                    if (eoi) begin
                        state_reg <= IDLE;
                    end
`endif
                end
                REQ_NEST: begin
                    if (cpu_ack) begin
                        state_reg   <= SERVICE;
                        int_out_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    int_out_reg <= 1'b0;
                end
            endcase
        end
    end

    assign int_out    = int_out_reg;
    assign nmi_out    = nmi_pend_reg;
    assign vector     = vector_reg;
    assign pending    = pending_reg;
    assign in_service = in_service_reg;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios with fixed
// expectations plus randomized traffic checked every cycle against a
// behavioural model built from the priority/acknowledge/eoi rules.
module tb_interrupt_controller;

    localparam int N  = 8;
    localparam int VW = 3;

    localparam int PH_IDLE  = 0;
    localparam int PH_OFFER = 1;
    localparam int PH_SERVE = 2;
    localparam int PH_NEST  = 3;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  irq;
    logic          nmi_in;
    logic          mask_we;
    logic [N-1:0]  mask_wdata;
    logic          int_ack;
    logic          eoi;
    logic          int_out;
    logic          nmi_out;
    logic [VW-1:0] vector;
    logic [N-1:0]  pending;
    logic [N-1:0]  in_service;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    bit m_mask     [N];
    bit m_pend     [N];
    bit m_isv      [N];
    bit m_irq_prev [N];
    bit m_nmi;
    bit m_nmi_prev;
    bit m_ack_prev;
    int m_phase;
    int m_vec;
    bit m_int;

    interrupt_controller #(.NUM_IRQ(N), .VEC_W(VW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq        (irq),
        .nmi_in     (nmi_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .int_ack    (int_ack),
        .eoi        (eoi),
        .int_out    (int_out),
        .nmi_out    (nmi_out),
        .vector     (vector),
        .pending    (pending),
        .in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] pack(input bit a [N]);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = a[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_mask[i] = 1'b1;
            m_pend[i] = 1'b0;
            m_isv[i] = 1'b0;
            m_irq_prev[i] = 1'b0;
        end
        m_nmi = 0; m_nmi_prev = 0; m_ack_prev = 0;
        m_phase = PH_IDLE; m_vec = 0; m_int = 0;
    endtask

    // Advance the model by one clock using the inputs the DUT is about to sample.
    task automatic model_step();
        bit ack_edge;
        int win;
        int low_isv;
        int next_low;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ack_edge = int_ack && !m_ack_prev;
        win = -1;
        for (int i = 0; i < N; i++)
            if (win < 0 && m_pend[i] && !m_mask[i]) win = i;
        low_isv = N;
        for (int i = N - 1; i >= 0; i--)
            if (m_isv[i]) low_isv = i;
        case (m_phase)
            PH_IDLE: begin
                if (win >= 0) begin m_phase = PH_OFFER; m_vec = win; m_int = 1; end
            end
            PH_OFFER, PH_NEST: begin
                if (ack_edge && !m_nmi) begin
                    m_pend[m_vec] = 0; m_isv[m_vec] = 1; m_int = 0; m_phase = PH_SERVE;
                end
            end
            PH_SERVE: begin
                if (eoi) begin
                    if (low_isv < N) m_isv[low_isv] = 0;
                    next_low = N;
                    for (int i = N - 1; i >= 0; i--)
                        if (m_isv[i]) next_low = i;
                    if (next_low == N) m_phase = PH_IDLE;
                    else m_vec = next_low;
                end
`ifdef NESTING_EN
                else if (win >= 0 && win < low_isv) begin
                    m_phase = PH_NEST; m_vec = win; m_int = 1;
                end
`endif
            end
            default: m_phase = PH_IDLE;
        endcase
        for (int i = 0; i < N; i++)
            if (irq[i] && !m_irq_prev[i]) m_pend[i] = 1;
        if (nmi_in && !m_nmi_prev) m_nmi = 1;
        else if (ack_edge && m_nmi) m_nmi = 0;
        if (mask_we)
            for (int i = 0; i < N; i++) m_mask[i] = mask_wdata[i];
        for (int i = 0; i < N; i++) m_irq_prev[i] = irq[i];
        m_nmi_prev = nmi_in;
        m_ack_prev = int_ack;
    endtask

    // One clock: step the model, let the edge pass, compare all outputs with the model.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (int_out !== m_int) begin
            $display("FAIL model_int_out t=%0t got=%b exp=%b", $time, int_out, m_int); errors++;
        end
        if (nmi_out !== m_nmi) begin
            $display("FAIL model_nmi_out t=%0t got=%b exp=%b", $time, nmi_out, m_nmi); errors++;
        end
        if (vector !== VW'(m_vec)) begin
            $display("FAIL model_vector t=%0t got=%0d exp=%0d", $time, vector, m_vec); errors++;
        end
        if (pending !== pack(m_pend)) begin
            $display("FAIL model_pending t=%0t got=%h exp=%h", $time, pending, pack(m_pend)); errors++;
        end
        if (in_service !== pack(m_isv)) begin
            $display("FAIL model_in_service t=%0t got=%h exp=%h", $time, in_service, pack(m_isv)); errors++;
        end
        checks += 5;
    endtask

    task automatic ack_pulse();
        int_ack = 1'b1; tick(); int_ack = 1'b0; tick();
    endtask

    task automatic eoi_pulse();
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        if (pending !== 8'h00 || in_service !== 8'h00 || int_out !== 1'b0 || nmi_out !== 1'b0 || vector !== 3'd0) begin
            $display("FAIL reset_outputs got pend=%h isv=%h int=%b nmi=%b vec=%0d exp all zero", pending, in_service, int_out, nmi_out, vector);
            errors++;
        end
        checks++;
        rst_n = 1'b1;
        irq[0] = 1'b1;
        tick(); tick(); tick();
        if (pending !== 8'h01 || int_out !== 1'b0) begin
            $display("FAIL reset_mask_all_ones got pend=%h int=%b exp pend=01 int=0", pending, int_out); errors++;
        end
        checks++;
        rst_n = 1'b0; irq = '0;
        tick();
        if (pending !== 8'h00) begin
            $display("FAIL reset_midway got pend=%h exp=00", pending); errors++;
        end
        checks++;
        irq[7] = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        if (pending !== 8'h80) begin
            $display("FAIL reset_held_high_edge got pend=%h exp=80", pending); errors++;
        end
        checks++;
        rst_n = 1'b0; irq = '0;
        tick();
        rst_n = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_basic();
        mask_we = 1'b1; mask_wdata = 8'h00; tick(); mask_we = 1'b0;
        irq[5] = 1'b1;
        tick();
        if (pending !== 8'h20 || int_out !== 1'b0) begin
            $display("FAIL basic_latency_k got pend=%h int=%b exp pend=20 int=0", pending, int_out); errors++;
        end
        checks++;
        tick();
        if (int_out !== 1'b1 || vector !== 3'd5) begin
            $display("FAIL basic_offer got int=%b vec=%0d exp int=1 vec=5", int_out, vector); errors++;
        end
        checks++;
        int_ack = 1'b1;
        tick();
        if (int_out !== 1'b0 || pending !== 8'h00 || in_service !== 8'h20) begin
            $display("FAIL basic_ack got int=%b pend=%h isv=%h exp int=0 pend=00 isv=20", int_out, pending, in_service); errors++;
        end
        checks++;
        tick(); tick();
        int_ack = 1'b0;
        tick();
        if (int_out !== 1'b0 || in_service !== 8'h20) begin
            $display("FAIL basic_held_ack got int=%b isv=%h exp int=0 isv=20", int_out, in_service); errors++;
        end
        checks++;
        eoi_pulse();
        if (in_service !== 8'h00) begin
            $display("FAIL basic_eoi got isv=%h exp=00", in_service); errors++;
        end
        checks++;
        irq = '0; tick();
        $display("test_basic done");
    endtask

    task automatic test_priority();
        irq[2] = 1'b1; irq[6] = 1'b1;
        tick(); tick();
        if (int_out !== 1'b1 || vector !== 3'd2 || pending !== 8'h44) begin
            $display("FAIL prio_first got int=%b vec=%0d pend=%h exp int=1 vec=2 pend=44", int_out, vector, pending); errors++;
        end
        checks++;
        ack_pulse();
        if (in_service !== 8'h04 || pending !== 8'h40 || int_out !== 1'b0) begin
            $display("FAIL prio_ack got isv=%h pend=%h int=%b exp isv=04 pend=40 int=0", in_service, pending, int_out); errors++;
        end
        checks++;
        eoi_pulse();
        if (int_out !== 1'b0) begin
            $display("FAIL prio_after_eoi got int=%b exp=0", int_out); errors++;
        end
        checks++;
        tick();
        if (int_out !== 1'b1 || vector !== 3'd6) begin
            $display("FAIL prio_second got int=%b vec=%0d exp int=1 vec=6", int_out, vector); errors++;
        end
        checks++;
        ack_pulse(); eoi_pulse();
        irq = '0; tick();
        $display("test_priority done");
    endtask

    task automatic test_mask();
        mask_we = 1'b1; mask_wdata = 8'h08; tick(); mask_we = 1'b0;
        irq[3] = 1'b1;
        tick(); tick(); tick();
        if (pending !== 8'h08 || int_out !== 1'b0) begin
            $display("FAIL mask_blocked got pend=%h int=%b exp pend=08 int=0", pending, int_out); errors++;
        end
        checks++;
        mask_we = 1'b1; mask_wdata = 8'h00; tick(); mask_we = 1'b0;
        if (int_out !== 1'b0) begin
            $display("FAIL mask_write_edge got int=%b exp=0", int_out); errors++;
        end
        checks++;
        tick();
        if (int_out !== 1'b1 || vector !== 3'd3) begin
            $display("FAIL mask_unmasked got int=%b vec=%0d exp int=1 vec=3", int_out, vector); errors++;
        end
        checks++;
        ack_pulse(); eoi_pulse();
        irq = '0; tick();
        $display("test_mask done");
    endtask

    task automatic test_nmi();
        irq[4] = 1'b1;
        tick(); tick();
        nmi_in = 1'b1;
        tick();
        if (nmi_out !== 1'b1 || int_out !== 1'b1 || vector !== 3'd4) begin
            $display("FAIL nmi_raise got nmi=%b int=%b vec=%0d exp nmi=1 int=1 vec=4", nmi_out, int_out, vector); errors++;
        end
        checks++;
        ack_pulse();
        if (nmi_out !== 1'b0 || int_out !== 1'b1 || vector !== 3'd4 || in_service !== 8'h00) begin
            $display("FAIL nmi_first_ack got nmi=%b int=%b vec=%0d isv=%h exp nmi=0 int=1 vec=4 isv=00", nmi_out, int_out, vector, in_service); errors++;
        end
        checks++;
        ack_pulse();
        if (in_service !== 8'h10 || int_out !== 1'b0) begin
            $display("FAIL nmi_second_ack got isv=%h int=%b exp isv=10 int=0", in_service, int_out); errors++;
        end
        checks++;
        nmi_in = 1'b0;
        $display("test_nmi done");
    endtask

    // Entered in service of vector 4.
    task automatic test_in_service_request();
        irq[1] = 1'b1;
        tick(); tick();
`ifdef NESTING_EN
        if (int_out !== 1'b1 || vector !== 3'd1) begin
            $display("FAIL nest_offer got int=%b vec=%0d exp int=1 vec=1", int_out, vector); errors++;
        end
        checks++;
        ack_pulse();
        if (in_service !== 8'h12 || int_out !== 1'b0) begin
            $display("FAIL nest_ack got isv=%h int=%b exp isv=12 int=0", in_service, int_out); errors++;
        end
        checks++;
        eoi_pulse();
        if (in_service !== 8'h10 || vector !== 3'd4) begin
            $display("FAIL nest_eoi1 got isv=%h vec=%0d exp isv=10 vec=4", in_service, vector); errors++;
        end
        checks++;
        eoi_pulse();
        if (in_service !== 8'h00) begin
            $display("FAIL nest_eoi2 got isv=%h exp=00", in_service); errors++;
        end
        checks++;
`else
        tick();
        if (int_out !== 1'b0 || pending !== 8'h02) begin
            $display("FAIL flat_hold got int=%b pend=%h exp int=0 pend=02", int_out, pending); errors++;
        end
        checks++;
        eoi_pulse();
        if (in_service !== 8'h00 || int_out !== 1'b0) begin
            $display("FAIL flat_eoi got isv=%h int=%b exp isv=00 int=0", in_service, int_out); errors++;
        end
        checks++;
        tick();
        if (int_out !== 1'b1 || vector !== 3'd1) begin
            $display("FAIL flat_after_eoi got int=%b vec=%0d exp int=1 vec=1", int_out, vector); errors++;
        end
        checks++;
        ack_pulse(); eoi_pulse();
`endif
        irq = '0; tick(); tick();
        $display("test_in_service_request done");
    endtask

    task automatic test_random();
        int ack_left;
        ack_left = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) irq[i] = ~irq[i];
            if ($urandom_range(0, 31) == 0) nmi_in = ~nmi_in;
            mask_we = ($urandom_range(0, 19) == 0);
            mask_wdata = N'($urandom & $urandom);
            if (ack_left > 0) begin
                int_ack = 1'b1; ack_left--;
            end else if (int_ack) begin
                int_ack = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                int_ack = 1'b1; ack_left = $urandom_range(0, 2);
            end
            eoi = ($urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 599) != 0);
            tick();
            if (int_ack && !m_ack_prev) ;
            if (c % 500 == 0)
                $display("random cycle %0d pend=%h isv=%h int=%b vec=%0d", c, pending, in_service, int_out, vector);
        end
        rst_n = 1'b1; mask_we = 1'b0; int_ack = 1'b0; eoi = 1'b0;
        tick();
        $display("test_random done");
    endtask

    initial begin
        rst_n = 1'b0; irq = '0; nmi_in = 1'b0; mask_we = 1'b0;
        mask_wdata = '0; int_ack = 1'b0; eoi = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_priority();
        test_mask();
        test_nmi();
        test_in_service_request();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
